// File: rtl/pcie_dma_chan_regs.sv
// pcie_dma_chan_regs: BAR0 register bank for a multi-channel DMA engine.
// Per-channel address/length/mode, start/abort doorbells, status, counters and a masked level irq.
module pcie_dma_chan_regs #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] DEF_ADDRH = 16'h0002,
    parameter logic [31:0] VERSION   = 32'h0002_0000
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [13:0]             rd_addr,
    input  logic [3:0]              rd_be,
    output logic [31:0]             rd_data,
    input  logic [13:0]             wr_addr,
    input  logic [7:0]              wr_be,
    input  logic [31:0]             wr_data,
    input  logic                    wr_en,
    output logic                    wr_busy,
    output logic [NUM_CH-1:0]       ch_start,
    output logic [NUM_CH-1:0]       ch_abort,
    output logic [3*NUM_CH-1:0]     ch_mode,
    output logic [48*NUM_CH-1:0]    ch_addr,
    output logic [32*NUM_CH-1:0]    ch_len,
    input  logic [NUM_CH-1:0]       ch_done,
    input  logic [NUM_CH-1:0]       ch_err,
    input  logic [CNT_W*NUM_CH-1:0] ch_tx_cnt,
    input  logic [CNT_W*NUM_CH-1:0] ch_rx_cnt,
    output logic                    irq
);

    // be[0] owns the most significant byte lane, be[3] the least significant.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[31-8*i -: 8] = new_val[31-8*i -: 8];
        end
        return res;
    endfunction

    logic              wr_bar;
    logic [4:0]        wr_ch_idx;
    logic              wr_ch_ok;
    logic [4:0]        rd_ch_idx;
    logic              rd_ch_ok;
    logic [NUM_CH-1:0] irq_en_q;
    logic [NUM_CH-1:0] pend;
    logic [31:0]       en_m;
    logic [31:0]       rd_word [NUM_CH];
    logic [31:0]       rd_mux;
    logic [31:0]       read_data;
    logic              unused_bits;

    assign wr_busy   = 1'b0;
    assign wr_bar    = wr_en && (wr_addr[13:12] == 2'b01);
    assign wr_ch_idx = wr_addr[7:3] - 5'd2;
    assign wr_ch_ok  = (wr_addr[7:3] >= 5'd2) && (wr_ch_idx < 5'(NUM_CH));
    assign rd_ch_idx = rd_addr[7:3] - 5'd2;
    assign rd_ch_ok  = (rd_addr[7:3] >= 5'd2) && (rd_ch_idx < 5'(NUM_CH));
    assign en_m      = lane_merge(32'(irq_en_q), wr_data, wr_be[3:0]);

    assign unused_bits = ^{rd_be, wr_be[7:4], wr_addr[11:8], rd_addr[11:8], en_m};

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            irq_en_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_bar && (wr_addr[7:0] == 8'h01)) irq_en_q <= en_m[NUM_CH-1:0];
            irq <= |(pend & irq_en_q);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic        hit;
        logic [29:0] addr_lo_q;
        logic [15:0] addr_hi_q;
        logic [29:0] len_q;
        logic [2:0]  mode_q;
        logic        busy_q, done_q, err_q, start_q, abort_q;
        logic        busy_d, done_d, err_d, start_d, abort_d;
        logic        ctrl_we, stat_we, start_req, abort_req;
        logic [31:0] lo_m, hi_m, len_m, rd_w;
        logic        unused_ch;

        assign hit       = wr_bar && wr_ch_ok && (wr_ch_idx == 5'(n));
        assign ctrl_we   = hit && (wr_addr[2:0] == 3'd0) && wr_be[3];
        assign stat_we   = hit && (wr_addr[2:0] == 3'd4) && wr_be[3];
        assign start_req = ctrl_we && wr_data[0];
        assign abort_req = ctrl_we && wr_data[1];
        assign lo_m      = lane_merge({addr_lo_q, 2'b00}, wr_data, wr_be[3:0]);
        assign hi_m      = lane_merge({16'h0, addr_hi_q}, wr_data, wr_be[3:0]);
        assign len_m     = lane_merge({len_q, 2'b00}, wr_data, wr_be[3:0]);
        assign unused_ch = ^{lo_m[1:0], hi_m[31:16], len_m[1:0]};

        // Engine events first; a doorbell in the same cycle has the final say on busy.
        always_comb begin
            busy_d  = busy_q;
            done_d  = done_q & ~(stat_we & wr_data[1]);
            err_d   = err_q  & ~(stat_we & wr_data[2]);
            start_d = 1'b0;
            abort_d = 1'b0;
            if (ch_done[n]) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            if (ch_err[n]) begin
                busy_d = 1'b0;
                err_d  = 1'b1;
            end
            if (abort_req && busy_q) begin
                abort_d = 1'b1;
                busy_d  = 1'b0;
            end else if (start_req) begin
                if (busy_q || (len_q == 30'd0)) begin
                    err_d = 1'b1;
                end else begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                addr_lo_q <= '0;
                addr_hi_q <= DEF_ADDRH;
                len_q     <= '0;
                mode_q    <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                start_q   <= 1'b0;
                abort_q   <= 1'b0;
            end else begin
                if (hit && (wr_addr[2:0] == 3'd1)) addr_lo_q <= lo_m[31:2];
                if (hit && (wr_addr[2:0] == 3'd2)) addr_hi_q <= hi_m[15:0];
                if (hit && (wr_addr[2:0] == 3'd3)) len_q     <= len_m[31:2];
                if (ctrl_we) mode_q <= wr_data[4:2];
                busy_q  <= busy_d;
                done_q  <= done_d;
                err_q   <= err_d;
                start_q <= start_d;
                abort_q <= abort_d;
            end
        end

        always_comb begin
            rd_w = '0;
            case (rd_addr[2:0])
                3'd0:    rd_w = {27'd0, mode_q, 2'b00};
                3'd1:    rd_w = {addr_lo_q, 2'b00};
                3'd2:    rd_w = {16'd0, addr_hi_q};
                3'd3:    rd_w = {len_q, 2'b00};
                3'd4:    rd_w = {29'd0, err_q, done_q, busy_q};
                3'd5:    rd_w = 32'(ch_tx_cnt[n*CNT_W +: CNT_W]);
                3'd6:    rd_w = 32'(ch_rx_cnt[n*CNT_W +: CNT_W]);
                default: rd_w = '0;
            endcase
        end

        assign rd_word[n]          = rd_w;
        assign pend[n]             = done_q | err_q;
        assign ch_start[n]         = start_q;
        assign ch_abort[n]         = abort_q;
        assign ch_mode[3*n +: 3]   = mode_q;
        assign ch_addr[48*n +: 48] = {addr_hi_q, addr_lo_q, 2'b00};
        assign ch_len[32*n +: 32]  = {len_q, 2'b00};
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr[7:0] == 8'h00) begin
            rd_mux = VERSION;
        end else if (rd_addr[7:0] == 8'h01) begin
            rd_mux = 32'(irq_en_q);
        end else if (rd_addr[7:0] == 8'h02) begin
            rd_mux = 32'(pend);
        end else if (rd_ch_ok) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (rd_ch_idx == 5'(n)) rd_mux = rd_word[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) read_data <= '0;
        else         read_data <= rd_mux;
    end

    assign rd_data = (rd_addr[13:12] == 2'b01) ? read_data : 32'h0;

endmodule
